multi_clk_div: RTL and testbench
================================

# multi_clk_div

Parametrised, multi-channel clock divider and tick generator for the countdown display datapath. It derives NUM_CH independent low-rate strobes or square waves from the 100 MHz board clock, such as the 1 Hz count strobe, the display-multiplex rate and the blink rate. Each channel's divisor and mode are reprogrammable at runtime, and changes apply glitch-free. All outputs are registered in the Clk domain and are intended as clock enables, not as derived clocks.

## Interface
- NUM_CH, 3, number of independent channels (1–8)
- CNT_W, 27, counter/terminal-count width; must hold DEF_TC
- DEF_TC, 49_999_999, reset terminal count of every channel
- DEF_MODE, 0, reset mode of every channel (0 = square, 1 = pulse)

Ports:
- Clk  in  1  system clock, 100 MHz
- Rst  in  1  reset, synchronous, active-high
- En  in  NUM_CH  per-channel run enable
- SyncRst  in  1  restarts all channel counters in the same cycle (phase align)
- LdEn  in  1  load strobe, one cycle
- LdCh  in  3  target channel of a load
- LdTc  in  CNT_W  new terminal count
- LdMode  in  1  new mode
- TcPend  out  NUM_CH  load captured, not yet active
- ClkOut  out  NUM_CH  per-channel output (square wave or one-cycle tick)

## Operation
- Each channel holds a counter Cnt, an active TC and mode, and a shadow TC and mode with a pending flag.
- Wrap event: En high and Cnt == active TC. On a wrap, Cnt is set to 0; otherwise, with En high, Cnt increments by 1.
- Square mode: ClkOut toggles on each wrap. Period is 2·(TC+1) cycles, with 50% duty.
- Pulse mode: ClkOut is high for exactly the cycle following each wrap edge. Period is TC+1 cycles.
- TC = 0: square mode toggles every cycle; pulse mode holds ClkOut high continuously.
- En low: Cnt holds at 0 and ClkOut is forced to 0. Re-enabling restarts the channel from Cnt = 0.
- Load: on LdEn with LdCh < NUM_CH, LdTc and LdMode are written to the shadow and TcPend[LdCh] is set. A load with LdCh ≥ NUM_CH is ignored.
  - The shadow is copied to the active registers at the next wrap, on SyncRst, or on the next cycle if the channel is disabled. TcPend clears in the same cycle.
  - A load coincident with a wrap of the same channel takes effect at that wrap, bypassing the shadow. TcPend stays 0.
  - A second load before the shadow is applied overwrites the first.
  - A mode change forces ClkOut to 0 at the apply edge.
- SyncRst: all Cnt are set to 0 and all ClkOut to 0, and pending shadows are applied. SyncRst takes priority over wrap. A load in the same cycle is applied directly.
- Rst, including mid-count: Cnt = 0, active and shadow TC = DEF_TC, mode = DEF_MODE, ClkOut = 0, TcPend = 0.
- Arithmetic: counters are unsigned CNT_W bits. Cnt never exceeds active TC, so there is no overflow wrap.

## Timing
- Edge 1 is the first rising edge with Rst low, and En is high from that edge. Cnt equals k after edge k.
- The first wrap occurs at edge TC+1, and ClkOut changes immediately after that edge.
- Outputs come directly from flops, with no combinational path from inputs.
- Load-to-active latency: 1 cycle if the channel is disabled, otherwise at most TC+1 cycles (until the next wrap).
- SyncRst: outputs are 0 the cycle after. The first wrap follows TC+1 edges later.

## Structure
- Package multi_clk_div_pkg holds the mode encoding (MODE_SQUARE = 0, MODE_PULSE = 1) and the CNT_W default.
- Sub-module clk_div_chan implements one channel (counter, active/shadow registers, output flop). The top level instantiates it NUM_CH times with a generate loop and decodes LdCh into per-channel load strobes.

## Test plan
- Reset defaults: CNT_W = 8, DEF_TC = 4, square mode, En = all 1 → ClkOut toggles after edges 5, 10, 15; period 10.
- Pulse mode: load TC = 2 into ch1 → TcPend[1] is 1 until the next wrap, then ClkOut[1] is high 1 cycle in every 3; ch0 and ch2 are unaffected.
- Boundaries: TC = 0 in pulse mode → ClkOut constantly 1. TC = 0 in square mode → toggles every cycle. LdCh = 7 with NUM_CH = 3 → no register changes.
- Coincident events: a load lands on the wrap edge → new TC is used from that wrap with TcPend = 0. SyncRst together with a load → all Cnt = 0 and the new value is active immediately.
- En and Rst mid-count: drop En[0] at Cnt = 3 → ClkOut[0] = 0 and Cnt holds at 0; re-enabling gives the first wrap TC+1 edges later. Assert Rst mid-count → all outputs 0 and TC = DEF_TC.

Source files
------------

// File: rtl/multi_clk_div_pkg.sv
// Shared encodings and defaults for the multi-channel clock divider.
package multi_clk_div_pkg;

  // Output mode of a channel: 50% square wave or one-cycle tick per wrap.
  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  // Counter width that holds the 1 Hz terminal count at 100 MHz.
  localparam int unsigned DefCntW = 27;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active and shadow TC/mode, registered output.
module clk_div_chan
  import multi_clk_div_pkg::*;
#(
  parameter int unsigned      CNT_W    = DefCntW,
  parameter logic [CNT_W-1:0] DEF_TC   = '1,
  parameter mode_e            DEF_MODE = MODE_SQUARE
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             en_i,
  input  logic             sync_rst_i,
  input  logic             ld_i,
  input  logic [CNT_W-1:0] ld_tc_i,
  input  logic             ld_mode_i,
  output logic             tc_pend_o,
  output logic             clk_out_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tc_q, tc_d;
  logic [CNT_W-1:0] sh_tc_q, sh_tc_d;
  mode_e            mode_q, mode_d;
  mode_e            sh_mode_q, sh_mode_d;
  logic             pend_q, pend_d;
  logic             out_q, out_d;

  // Next-state: phase-align/disable first, then wrap, then plain count.
  always_comb begin
    cnt_d     = cnt_q;
    tc_d      = tc_q;
    mode_d    = mode_q;
    sh_tc_d   = sh_tc_q;
    sh_mode_d = sh_mode_q;
    pend_d    = pend_q;
    out_d     = out_q;
    if (sync_rst_i || !en_i) begin
      cnt_d = '0;
      out_d = 1'b0;
      if (pend_q) begin
        tc_d   = sh_tc_q;
        mode_d = sh_mode_q;
        pend_d = 1'b0;
      end
      if (ld_i) begin
        if (sync_rst_i) begin
          // Load alongside SyncRst goes straight to the active registers.
          tc_d   = ld_tc_i;
          mode_d = mode_e'(ld_mode_i);
          pend_d = 1'b0;
        end else begin
          // Disabled: park in the shadow, applied on the following cycle.
          sh_tc_d   = ld_tc_i;
          sh_mode_d = mode_e'(ld_mode_i);
          pend_d    = 1'b1;
        end
      end
    end else if (cnt_q == tc_q) begin
      cnt_d = '0;
      if (ld_i) begin
        tc_d   = ld_tc_i;
        mode_d = mode_e'(ld_mode_i);
        pend_d = 1'b0;
      end else if (pend_q) begin
        tc_d   = sh_tc_q;
        mode_d = sh_mode_q;
        pend_d = 1'b0;
      end
      // A mode switch restarts the output low so no runt level leaks out.
      if (mode_d != mode_q) begin
        out_d = 1'b0;
      end else if (mode_q == MODE_SQUARE) begin
        out_d = ~out_q;
      end else begin
        out_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (mode_q == MODE_PULSE) begin
        out_d = 1'b0;
      end
      if (ld_i) begin
        sh_tc_d   = ld_tc_i;
        sh_mode_d = mode_e'(ld_mode_i);
        pend_d    = 1'b1;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q     <= '0;
      tc_q      <= DEF_TC;
      sh_tc_q   <= DEF_TC;
      mode_q    <= DEF_MODE;
      sh_mode_q <= DEF_MODE;
      pend_q    <= 1'b0;
      out_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tc_q      <= tc_d;
      sh_tc_q   <= sh_tc_d;
      mode_q    <= mode_d;
      sh_mode_q <= sh_mode_d;
      pend_q    <= pend_d;
      out_q     <= out_d;
    end
  end

  assign tc_pend_o = pend_q;
  assign clk_out_o = out_q;

endmodule

// File: rtl/multi_clk_div.sv
// NUM_CH independent clock-enable generators with glitch-free runtime reload.
module multi_clk_div
  import multi_clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned CNT_W    = DefCntW,
  parameter int unsigned DEF_TC   = 49_999_999,
  parameter bit          DEF_MODE = 1'b0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [NUM_CH-1:0] En,
  input  logic              SyncRst,
  input  logic              LdEn,
  input  logic [2:0]        LdCh,
  input  logic [CNT_W-1:0]  LdTc,
  input  logic              LdMode,
  output logic [NUM_CH-1:0] TcPend,
  output logic [NUM_CH-1:0] ClkOut
);

  logic [NUM_CH-1:0] ld_vec;

  // Decode the load target; channel numbers past NUM_CH-1 match nothing.
  always_comb begin
    ld_vec = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (LdEn && (LdCh == 3'(i))) begin
        ld_vec[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DEF_TC  (CNT_W'(DEF_TC)),
      .DEF_MODE(mode_e'(DEF_MODE))
    ) u_chan (
      .Clk       (Clk),
      .Rst       (Rst),
      .en_i      (En[g]),
      .sync_rst_i(SyncRst),
      .ld_i      (ld_vec[g]),
      .ld_tc_i   (LdTc),
      .ld_mode_i (LdMode),
      .tc_pend_o (TcPend[g]),
      .clk_out_o (ClkOut[g])
    );
  end

endmodule

// File: tb/tb_multi_clk_div.sv
// Scoreboard bench: stimulus pushes hand-derived expectations per edge, monitor checks them.
module tb_multi_clk_div;

  localparam int unsigned NumCh = 3;
  localparam int unsigned CntW  = 8;
  localparam int unsigned LastK = 105;

  logic             Clk = 1'b0;
  logic             Rst;
  logic [NumCh-1:0] En;
  logic             SyncRst;
  logic             LdEn;
  logic [2:0]       LdCh;
  logic [CntW-1:0]  LdTc;
  logic             LdMode;
  logic [NumCh-1:0] TcPend;
  logic [NumCh-1:0] ClkOut;

  multi_clk_div #(
    .NUM_CH  (NumCh),
    .CNT_W   (CntW),
    .DEF_TC  (4),
    .DEF_MODE(1'b0)
  ) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .En     (En),
    .SyncRst(SyncRst),
    .LdEn   (LdEn),
    .LdCh   (LdCh),
    .LdTc   (LdTc),
    .LdMode (LdMode),
    .TcPend (TcPend),
    .ClkOut (ClkOut)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0] out;
    logic [2:0] pend;
    int         k;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // Expected ClkOut after edge k (edge 1 = first edge with Rst low).
  function automatic logic [2:0] exp_out(int k);
    logic o0, o1, o2;
    int   p;
    p = (k / 5) % 2;
    if (k <= 62) begin
      o0 = (p == 1);
      if (k < 25)      o1 = (p == 1);
      else if (k < 43) o1 = (k >= 28) && ((k - 28) % 3 == 0);
      else             o1 = 1'b1;
      o2 = (k < 55) ? (p == 1) : ((k - 55) % 2 == 0);
    end else if (k <= 70) begin
      o0 = (k >= 65) && ((k - 65) % 2 == 0);
      o1 = (k >= 64);
      o2 = (k >= 64) && ((k - 64) % 2 == 0);
    end else if (k <= 93) begin
      o0 = ((k >= 77) && (k <= 80)) || ((k >= 87) && (k <= 91));
      o1 = 1'b1;
      o2 = (k % 2 == 0);
    end else if (k == 94) begin
      o0 = 1'b0; o1 = 1'b0; o2 = 1'b0;
    end else begin
      o0 = (k >= 99) && (k <= 103);
      o1 = o0;
      o2 = o0;
    end
    return {o2, o1, o0};
  endfunction

  function automatic logic [2:0] exp_pend(int k);
    if ((k >= 21) && (k <= 24)) return 3'b010;
    if ((k == 53) || (k == 54)) return 3'b100;
    if ((k == 71) || (k == 93)) return 3'b001;
    return 3'b000;
  endfunction

  function automatic string phase(int k);
    if (k == 0)  return "reset";
    if (k <= 20) return "square_default";
    if (k <= 42) return "pulse_load_ch1";
    if (k <= 50) return "load_on_wrap";
    if (k <= 62) return "ignored_ch7_tc0_square";
    if (k <= 70) return "syncrst_with_load";
    if (k <= 92) return "en_drop";
    if (k <= 94) return "rst_midcount";
    return "post_rst_defaults";
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(int k);
    exp_t e;
    e.out  = exp_out(k);
    e.pend = exp_pend(k);
    e.k    = k;
    e.tag  = phase(k);
    sb_q.push_back(e);
  endtask

  // Input changes made after checking edge k, taking effect at edge k+1.
  task automatic drive(int k);
    case (k)
      20: begin LdEn = 1'b1; LdCh = 3'd1; LdTc = 8'd2; LdMode = 1'b1; end
      21: LdEn = 1'b0;
      42: begin LdEn = 1'b1; LdCh = 3'd1; LdTc = 8'd0; LdMode = 1'b1; end
      43: LdEn = 1'b0;
      50: begin LdEn = 1'b1; LdCh = 3'd7; LdTc = 8'd0; LdMode = 1'b1; end
      51: LdEn = 1'b0;
      52: begin LdEn = 1'b1; LdCh = 3'd2; LdTc = 8'd0; LdMode = 1'b0; end
      53: LdEn = 1'b0;
      62: begin SyncRst = 1'b1; LdEn = 1'b1; LdCh = 3'd0; LdTc = 8'd1; LdMode = 1'b1; end
      63: begin SyncRst = 1'b0; LdEn = 1'b0; end
      70: begin En = 3'b110; LdEn = 1'b1; LdCh = 3'd0; LdTc = 8'd4; LdMode = 1'b0; end
      71: LdEn = 1'b0;
      72: En = 3'b111;
      80: En = 3'b110;
      82: En = 3'b111;
      92: begin LdEn = 1'b1; LdCh = 3'd0; LdTc = 8'd9; LdMode = 1'b0; end
      93: begin LdEn = 1'b0; Rst = 1'b1; end
      94: Rst = 1'b0;
      default: ;
    endcase
  endtask

  // Monitor: every output sample away from the active edge settles pending expectations.
  always @(negedge Clk) begin
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      total++;
      if ((ClkOut !== mon_e.out) || (TcPend !== mon_e.pend)) begin
        bad++;
        $display("FAIL %s edge %0d: ClkOut=%b TcPend=%b, required ClkOut=%b TcPend=%b",
                 mon_e.tag, mon_e.k, ClkOut, TcPend, mon_e.out, mon_e.pend);
      end
    end
  end

  initial begin
    Rst     = 1'b1;
    En      = 3'b111;
    SyncRst = 1'b0;
    LdEn    = 1'b0;
    LdCh    = 3'd0;
    LdTc    = 8'd0;
    LdMode  = 1'b0;
    tick();
    tick();
    push(0);
    Rst = 1'b0;
    for (int k = 1; k <= int'(LastK); k++) begin
      tick();
      push(k);
      drive(k);
    end
    tick();
    @(negedge Clk);
    #1;
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
